hop_ctrl: RTL and testbench
===========================

HOP_CTRL -- requirements
Module: hop_ctrl

Interface
REQ-001 SHALL have parameter SCAN_WIDTH, default 2, the length in clk cycles of each phi, phi_bar and load pulse (must be ≥1).
REQ-002 SHALL have parameter NTX_BITS, default 78, the number of serial bits shifted per run (1..TX_BITS_WIDTH).
REQ-003 SHALL have parameter TX_BITS_WIDTH, default 128, the width of data_in.
REQ-004 SHALL have parameter BIT_CNT_WIDTH, default 7, the width of nbits_cnt (must satisfy 2^BIT_CNT_WIDTH > NTX_BITS).
REQ-005 Port clk, input, 1: the single clock; all logic is rising-edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset that restarts a run.
REQ-007 Port data_in, input, TX_BITS_WIDTH: the parallel word to shift; sampled live, and the caller holds it stable for the whole run.
REQ-008 Port scan_id, output, 1: chip-select, high for the whole run.
REQ-009 Port scan_phi, output, 1: first non-overlapping shift phase.
REQ-010 Port scan_phi_bar, output, 1: second non-overlapping shift phase.
REQ-011 Port scan_data_in, output, 1: the serial data bit.
REQ-012 Port scan_load_chip, output, 1: parallel-load strobe.
REQ-013 Port nbits_cnt, output, BIT_CNT_WIDTH: the number of bits fully shifted so far.

Function
REQ-014 SHALL implement a Moore FSM with states IDLE, SETUP, PHI, HOLD, PHI_BAR, LOAD_GAP, LOAD and DONE.
REQ-015 All outputs SHALL be decoded only from the registered state, the bit index b and the pulse counter.
REQ-016 Timing is counted as c = the number of rising edges since reset release; P = 2*SCAN_WIDTH+2 and N = NTX_BITS.
REQ-017 IDLE SHALL last exactly one cycle (c=0); all outputs are 0.
REQ-018 Bit b (0..N-1) SHALL occupy cycles 1+b*P through (b+1)*P, in this order:
- SETUP for 1 cycle
- PHI for SCAN_WIDTH cycles
- HOLD for 1 cycle
- PHI_BAR for SCAN_WIDTH cycles
REQ-019 scan_phi SHALL be high only in PHI, and scan_phi_bar only in PHI_BAR; the two are never high in the same cycle and are always separated by at least 1 low cycle.
REQ-020 In states SETUP, PHI, HOLD and PHI_BAR of bit b, scan_data_in SHALL equal data_in[N-1-b] (MSB first); in all other states it is 0.
REQ-021 nbits_cnt SHALL increment by 1 on the edge that leaves the last PHI_BAR cycle of each bit; it equals b during bit b, reaches N, and holds N thereafter.
REQ-022 LOAD_GAP SHALL occupy the single cycle c=1+N*P, with phi, phi_bar, data and load all 0.
REQ-023 LOAD SHALL occupy c=2+N*P through 1+N*P+SCAN_WIDTH, with scan_load_chip=1.
REQ-024 DONE SHALL be entered at c=2+N*P+SCAN_WIDTH and is absorbing: all outputs are 0 except nbits_cnt=N; DONE is left only by reset.
REQ-025 scan_id SHALL be 1 in every state except IDLE and DONE.
REQ-026 Changes of data_in during a run SHALL take effect immediately on scan_data_in; there is no internal latch.
REQ-027 An unreachable state encoding SHALL go to IDLE on the next edge.

Reset
REQ-028 While reset=1, the block SHALL hold state=IDLE, b=0, pulse counter=0 and nbits_cnt=0, so every output is 0.
REQ-029 Reset asserted mid-shift or in DONE SHALL abort immediately; the full sequence restarts from c=0 after release, with no residual pulse.

Structure
REQ-030 A shared package SHALL hold the state enum and the derived constant P (bit period); the parameters remain module parameters.
REQ-031 The block SHALL be a single module with no sub-module: one state register, one bit-index counter and one SCAN_WIDTH pulse counter.

Verification
REQ-032 Defaults with reset held -> all outputs 0; after release c=0 shows IDLE with outputs 0, and c=1 shows scan_id=1 and scan_data_in=data_in[77].
REQ-033 Defaults: phi high at c=2..3, phi_bar high at c=5..6, next SETUP at c=7 with nbits_cnt=1 and data=data_in[76]; no cycle has phi&phi_bar.
REQ-034 data_in=128'h...A5 pattern -> the serial stream captured at each phi rising edge reconstructs data_in[77:0] MSB-first.
REQ-035 Defaults -> LOAD_GAP at c=469, scan_load_chip high at c=470..471, DONE from c=472 with nbits_cnt=78 held for 1000 cycles and scan_id=0.
REQ-036 Reset pulsed at c=200 -> outputs go 0 asynchronously, and the sequence restarts with identical timing from the new release.
REQ-037 NTX_BITS=1, SCAN_WIDTH=1 -> P=4, bit at c=1..4, LOAD_GAP c=5, load c=6, DONE c=7 with nbits_cnt=1.

Source files
------------

// File: rtl/hop_ctrl_pkg.sv
// hop_ctrl_pkg: shared state encoding and bit-period helper for the scan-chain shifter
package hop_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE, SETUP, PHI, HOLD, PHI_BAR, LOAD_GAP, LOAD, DONE
  } state_t;
  function automatic int bit_period(input int scan_width);
    return 2 * scan_width + 2;
  endfunction
endpackage

// File: rtl/hop_ctrl.sv
// hop_ctrl: shifts NTX_BITS of data_in MSB-first with two non-overlapping phases, then strobes load
module hop_ctrl
  import hop_ctrl_pkg::*;
#(
  parameter int SCAN_WIDTH    = 2,
  parameter int NTX_BITS      = 78,
  parameter int TX_BITS_WIDTH = 128,
  parameter int BIT_CNT_WIDTH = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [TX_BITS_WIDTH-1:0] data_in,
  output logic                     scan_id,
  output logic                     scan_phi,
  output logic                     scan_phi_bar,
  output logic                     scan_data_in,
  output logic                     scan_load_chip,
  output logic [BIT_CNT_WIDTH-1:0] nbits_cnt
);
  localparam int PW = SCAN_WIDTH > 1 ? $clog2(SCAN_WIDTH) : 1;
  localparam logic [PW-1:0] PC_LAST = PW'(SCAN_WIDTH - 1);
  localparam logic [BIT_CNT_WIDTH-1:0] B_LAST = BIT_CNT_WIDTH'(NTX_BITS - 1);
  state_t state;
  logic [BIT_CNT_WIDTH-1:0] b;
  logic [PW-1:0] pc;
  logic [TX_BITS_WIDTH-1:0] aligned;
  logic shifting;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      b     <= '0;
      pc    <= '0;
    end else begin
      case (state)
        IDLE:     state <= SETUP;
        SETUP:    begin state <= PHI; pc <= '0; end
        PHI:      if (pc == PC_LAST) begin state <= HOLD; pc <= '0; end else pc <= pc + 1'b1;
        HOLD:     state <= PHI_BAR;
        PHI_BAR:
          if (pc == PC_LAST) begin
            pc    <= '0;
            b     <= b + 1'b1;
            state <= b == B_LAST ? LOAD_GAP : SETUP;
          end else pc <= pc + 1'b1;
        LOAD_GAP: begin state <= LOAD; pc <= '0; end
        LOAD:     if (pc == PC_LAST) begin state <= DONE; pc <= '0; end else pc <= pc + 1'b1;
        DONE:     state <= DONE;
        default:  begin state <= IDLE; b <= '0; pc <= '0; end
      endcase
    end
  end
  // data_in is read live: bit N-1-b lands on position N-1 after the shift
  assign aligned        = data_in << b;
  assign shifting       = state == SETUP || state == PHI || state == HOLD || state == PHI_BAR;
  assign scan_id        = state != IDLE && state != DONE;
  assign scan_phi       = state == PHI;
  assign scan_phi_bar   = state == PHI_BAR;
  assign scan_data_in   = shifting & aligned[NTX_BITS-1];
  assign scan_load_chip = state == LOAD;
  assign nbits_cnt      = b;
endmodule

// File: tb/tb_hop_ctrl.sv
// tb_hop_ctrl: table-driven cycle checks of the default and minimal hop_ctrl configurations
module tb_hop_ctrl;
  logic clk = 0;
  logic reset = 1;
  logic [127:0] data_in = {16{8'hA5}};
  logic a_id, a_phi, a_pbar, a_data, a_load;
  logic [6:0] a_nb;
  logic b_id, b_phi, b_pbar, b_data, b_load;
  logic [6:0] b_nb;
  int checks = 0;
  int fails = 0;

  hop_ctrl dut_a (
    .clk(clk), .reset(reset), .data_in(data_in),
    .scan_id(a_id), .scan_phi(a_phi), .scan_phi_bar(a_pbar),
    .scan_data_in(a_data), .scan_load_chip(a_load), .nbits_cnt(a_nb)
  );
  hop_ctrl #(.SCAN_WIDTH(1), .NTX_BITS(1)) dut_b (
    .clk(clk), .reset(reset), .data_in(data_in),
    .scan_id(b_id), .scan_phi(b_phi), .scan_phi_bar(b_pbar),
    .scan_data_in(b_data), .scan_load_chip(b_load), .nbits_cnt(b_nb)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         c;
    logic [4:0] o;
    int         nb;
  } vec_t;
  vec_t va[15];
  vec_t vb[8];

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s c=%0d got %h expected %h", name, c, act, exp);
    end
  endtask

  // {scan_id, phi, phi_bar, data, load}
  task automatic run(input int last_c, output logic [77:0] rec, output int ncap, output int overlap);
    logic prev_phi;
    prev_phi = 0;
    rec = '0;
    ncap = 0;
    overlap = 0;
    for (int c = 0; c <= last_c; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      foreach (va[i]) if (va[i].c == c) begin
        chk("a_out", c, {27'd0, a_id, a_phi, a_pbar, a_data, a_load}, {27'd0, va[i].o});
        chk("a_nbits", c, {25'd0, a_nb}, va[i].nb);
      end
      foreach (vb[i]) if (vb[i].c == c) begin
        chk("b_out", c, {27'd0, b_id, b_phi, b_pbar, b_data, b_load}, {27'd0, vb[i].o});
        chk("b_nbits", c, {25'd0, b_nb}, vb[i].nb);
      end
      if (a_phi && !prev_phi) begin
        rec = {rec[76:0], a_data};
        ncap++;
      end
      if (a_phi && a_pbar) overlap++;
      prev_phi = a_phi;
    end
  endtask

  initial begin
    logic [77:0] rec;
    int ncap, overlap, bad;
    va[0]  = '{0,   5'b00000, 0};
    va[1]  = '{1,   5'b10010, 0};
    va[2]  = '{2,   5'b11010, 0};
    va[3]  = '{3,   5'b11010, 0};
    va[4]  = '{4,   5'b10010, 0};
    va[5]  = '{5,   5'b10110, 0};
    va[6]  = '{6,   5'b10110, 0};
    va[7]  = '{7,   5'b10000, 1};
    va[8]  = '{8,   5'b11000, 1};
    va[9]  = '{31,  5'b10010, 5};
    va[10] = '{468, 5'b10110, 77};
    va[11] = '{469, 5'b10000, 78};
    va[12] = '{470, 5'b10001, 78};
    va[13] = '{471, 5'b10001, 78};
    va[14] = '{472, 5'b00000, 78};
    vb[0]  = '{0, 5'b00000, 0};
    vb[1]  = '{1, 5'b10010, 0};
    vb[2]  = '{2, 5'b11010, 0};
    vb[3]  = '{3, 5'b10010, 0};
    vb[4]  = '{4, 5'b10110, 0};
    vb[5]  = '{5, 5'b10000, 1};
    vb[6]  = '{6, 5'b10001, 1};
    vb[7]  = '{7, 5'b00000, 1};
    repeat (3) @(negedge clk);
    #1;
    chk("reset_held", 0, {18'd0, a_id, a_phi, a_pbar, a_data, a_load, a_nb}, 32'd0);
    @(negedge clk);
    reset = 0;
    run(472, rec, ncap, overlap);
    chk("capture_count", 0, ncap, 78);
    chk("reconstruct", 0, rec[31:0], data_in[31:0]);
    chk("reconstruct_hi", 0, {18'd0, rec[77:64]}, {18'd0, data_in[77:64]});
    chk("no_overlap", 0, overlap, 0);
    // abort mid-shift, checked before any further clock edge
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    run(200, rec, ncap, overlap);
    #2 reset = 1;
    #1;
    chk("async_reset_a", 200, {18'd0, a_id, a_phi, a_pbar, a_data, a_load, a_nb}, 32'd0);
    chk("async_reset_b", 200, {18'd0, b_id, b_phi, b_pbar, b_data, b_load, b_nb}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 0;
    run(472, rec, ncap, overlap);
    chk("rerun_reconstruct", 0, rec[31:0], data_in[31:0]);
    chk("rerun_overlap", 0, overlap, 0);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      #1;
      if ({a_id, a_phi, a_pbar, a_data, a_load} !== 5'b0 || a_nb !== 7'd78) bad++;
    end
    chk("done_hold", 1000, bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
